// File: rtl/loader_pkg.sv
// Shared types and frame constants for the program loader slice.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_BITS  = 8;
  localparam int WORD_BITS  = WORD_BYTES * BYTE_BITS;
  localparam int COUNT_BITS = WORD_BITS;

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready byte link feeding the loader; master is the byte source.
interface program_loader_if;
  import loader_pkg::*;

  logic                 rx_valid;
  logic [BYTE_BITS-1:0] rx_data;
  logic                 rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Collects little-endian bytes into words; word_valid pulses with the last byte.
module byte_assembler
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 byte_en,
  input  logic [BYTE_BITS-1:0] byte_in,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0]                      byte_cnt;
  logic [(WORD_BYTES-1)*BYTE_BITS-1:0]   partial;

  // Earlier bytes shift down so the first byte received lands in the LSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (byte_en) begin
      partial  <= {byte_in, partial[(WORD_BYTES-1)*BYTE_BITS-1:BYTE_BITS]};
      byte_cnt <= (byte_cnt == LAST) ? '0 : byte_cnt + CNT_W'(1);
    end
  end

  assign word_valid = byte_en && (byte_cnt == LAST);
  assign word       = {byte_in, partial};

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a counted, XOR-checked image and writes it into SRAM
// before releasing the cpu.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  program_loader_if.slave       rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_BITS-1:0]  mem_wdata,
  output logic                  cpu_run,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t                state;
  logic [COUNT_BITS-1:0] n_words;
  logic [BYTE_BITS-1:0]  csum;
  logic                  accept;
  logic                  asm_en;
  logic                  word_valid;
  logic [WORD_BITS-1:0]  asm_word;
  logic                  last_word;

  assign rx.rx_ready = (state == HDR) || (state == DATA) || (state == CSUM);
  assign accept      = rx.rx_valid && rx.rx_ready && !start;
  assign asm_en      = accept && ((state == HDR) || (state == DATA));
  assign last_word   = (COUNT_BITS'(words_loaded) + COUNT_BITS'(1)) == n_words;

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .byte_en    (asm_en),
    .byte_in    (rx.rx_data),
    .word_valid (word_valid),
    .word       (asm_word)
  );

  // mem_we is a one-cycle strobe, so a write registered before a restart still issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      n_words      <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_run      <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        state        <= HDR;
        n_words      <= '0;
        csum         <= '0;
        cpu_run      <= 1'b0;
        load_done    <= 1'b0;
        load_err     <= 1'b0;
        words_loaded <= '0;
      end else begin
        if (accept && (state != CSUM)) begin
          csum <= csum ^ rx.rx_data;
        end
        case (state)
          HDR: begin
            if (word_valid) begin
              n_words <= asm_word;
              if (asm_word > COUNT_BITS'(MAX_WORDS)) begin
                state    <= ERR;
                load_err <= 1'b1;
              end else if (asm_word == '0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (word_valid) begin
              mem_we       <= 1'b1;
              mem_addr     <= BASE + words_loaded[ADDR_WIDTH-1:0];
              mem_wdata    <= asm_word;
              words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
              if (last_word) begin
                state <= CSUM;
              end
            end
          end
          CSUM: begin
            if (accept) begin
              if (rx.rx_data == csum) begin
                state     <= RUN;
                load_done <= 1'b1;
                cpu_run   <= 1'b1;
              end else begin
                state    <= ERR;
                load_err <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench: two loaders (base 0 and base 1020) share one byte stream.
module tb_program_loader;

  localparam int AW   = 10;
  localparam int MAXW = 1024;
  localparam int B0   = 0;
  localparam int B1   = 1020;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;

  program_loader_if rx0 ();
  program_loader_if rx1 ();
  assign rx1.rx_valid = rx0.rx_valid;
  assign rx1.rx_data  = rx0.rx_data;

  logic          we0, run0, done0, err0;
  logic [AW-1:0] addr0;
  logic [31:0]   wd0;
  logic [AW:0]   wl0;
  logic          we1, run1, done1, err1;
  logic [AW-1:0] addr1;
  logic [31:0]   wd1;
  logic [AW:0]   wl1;

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(B0), .MAX_WORDS(MAXW)) dut0 (
    .clk(clk), .rst(rst), .start(start), .rx(rx0),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0), .cpu_run(run0),
    .load_done(done0), .load_err(err0), .words_loaded(wl0)
  );

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(B1), .MAX_WORDS(MAXW)) dut1 (
    .clk(clk), .rst(rst), .start(start), .rx(rx1),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .cpu_run(run1),
    .load_done(done1), .load_err(err1), .words_loaded(wl1)
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  wr_t q0[$];
  wr_t q1[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected write for every strobe each loader presents.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (we0) begin
        if (q0.size() == 0) checkOutput("unexpected_write0", {addr0, wd0}, 64'h0);
        else begin
          e = q0.pop_front();
          checkOutput("write0", {addr0, wd0}, {e.addr, e.data});
        end
      end
      if (we1) begin
        if (q1.size() == 0) checkOutput("unexpected_write1", {addr1, wd1}, 64'h0);
        else begin
          e = q1.pop_front();
          checkOutput("write1", {addr1, wd1}, {e.addr, e.data});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx0.rx_valid = 1'b1;
    rx0.rx_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (rx0.rx_ready) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    checkOutput("rx_ready_timeout", 64'h0, 64'h1);
  endtask

  task automatic pulseStart(input bit with_byte);
    @(negedge clk);
    start        = 1'b1;
    rx0.rx_valid = with_byte;
    rx0.rx_data  = 8'hA5;
    @(negedge clk);
    start        = 1'b0;
    rx0.rx_valid = 1'b0;
  endtask

  task automatic buildFrame(input int n, input logic [31:0] words[$], input bit corrupt,
                            output logic [7:0] f[$]);
    logic [7:0] x;
    logic [31:0] nn;
    f  = {};
    nn = n;
    for (int i = 0; i < 4; i++) f.push_back(nn[8*i +: 8]);
    for (int w = 0; w < words.size(); w++)
      for (int i = 0; i < 4; i++) f.push_back(words[w][8*i +: 8]);
    x = 8'h00;
    foreach (f[i]) x = x ^ f[i];
    f.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  // Sends up to stop_after bytes; expected writes come from the frame layout alone.
  task automatic applyStimulus(input logic [7:0] f[$], input int stop_after, input bit gaps,
                               output int n_writes);
    logic [31:0] n;
    int limit;
    int idx;
    n        = {f[3], f[2], f[1], f[0]};
    limit    = (stop_after < f.size()) ? stop_after : f.size();
    n_writes = 0;
    for (int k = 0; k < limit; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        @(negedge clk);
        rx0.rx_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      sendByte(f[k]);
      if (n <= MAXW && k >= 4 && k < 4 + 4 * int'(n) && ((k - 4) % 4) == 3) begin
        idx = (k - 4) / 4;
        q0.push_back('{addr: AW'((B0 + idx) % (1 << AW)), data: {f[k], f[k-1], f[k-2], f[k-3]}});
        q1.push_back('{addr: AW'((B1 + idx) % (1 << AW)), data: {f[k], f[k-1], f[k-2], f[k-3]}});
        n_writes++;
      end
      if (n > MAXW && k == 3) break;
    end
    @(negedge clk);
    rx0.rx_valid = 1'b0;
  endtask

  task automatic checkStatus(input string tag, input bit done, input bit err, input int wl);
    checkOutput({tag, "_done0"}, 64'(done0), 64'(done));
    checkOutput({tag, "_err0"},  64'(err0),  64'(err));
    checkOutput({tag, "_run0"},  64'(run0),  64'(done));
    checkOutput({tag, "_wl0"},   64'(wl0),   64'(wl));
    checkOutput({tag, "_done1"}, 64'(done1), 64'(done));
    checkOutput({tag, "_err1"},  64'(err1),  64'(err));
    checkOutput({tag, "_wl1"},   64'(wl1),   64'(wl));
    checkOutput({tag, "_pending"}, 64'(q0.size() + q1.size()), 64'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_outs0"}, {we0, addr0, wd0, run0, done0, err0, wl0, rx0.rx_ready}, 64'h0);
    checkOutput({tag, "_outs1"}, {we1, addr1, wd1, run1, done1, err1, wl1, rx1.rx_ready}, 64'h0);
  endtask

  initial begin
    logic [7:0]  f[$];
    logic [31:0] w[$];
    int nw;
    int n;
    bit bad;

    rst          = 1'b1;
    start        = 1'b0;
    rx0.rx_valid = 1'b0;
    rx0.rx_data  = 8'h00;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic image");
    pulseStart(1'b0);
    w = {32'h0000_0013, 32'hDEAD_BEEF};
    buildFrame(2, w, 1'b0, f);
    applyStimulus(f, 1000, 1'b0, nw);
    checkStatus("basic", 1'b1, 1'b0, 2);

    $display("[TB] checksum error");
    pulseStart(1'b0);
    buildFrame(2, w, 1'b1, f);
    applyStimulus(f, 1000, 1'b0, nw);
    checkStatus("csum_err", 1'b0, 1'b1, 2);

    $display("[TB] oversize count");
    pulseStart(1'b0);
    w = {};
    buildFrame(MAXW + 1, w, 1'b0, f);
    applyStimulus(f, 1000, 1'b0, nw);
    checkOutput("oversize_ready", 64'(rx0.rx_ready), 64'h0);
    checkStatus("oversize", 1'b0, 1'b1, 0);
    repeat (5) begin
      @(negedge clk);
      rx0.rx_valid = 1'b1;
      rx0.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx0.rx_valid = 1'b0;
    checkStatus("oversize_after", 1'b0, 1'b1, 0);

    $display("[TB] empty image");
    pulseStart(1'b0);
    buildFrame(0, w, 1'b0, f);
    applyStimulus(f, 1000, 1'b0, nw);
    checkStatus("empty", 1'b1, 1'b0, 0);

    $display("[TB] restart mid-data with gaps");
    pulseStart(1'b0);
    w = {32'($urandom), 32'($urandom), 32'($urandom)};
    buildFrame(3, w, 1'b0, f);
    applyStimulus(f, 10, 1'b0, nw);
    pulseStart(1'b1);
    checkStatus("restart_clear", 1'b0, 1'b0, 0);
    w = {32'($urandom), 32'($urandom), 32'($urandom)};
    buildFrame(3, w, 1'b0, f);
    applyStimulus(f, 1000, 1'b1, nw);
    checkStatus("restart", 1'b1, 1'b0, 3);

    $display("[TB] eight words, address wrap on the 1020 loader");
    pulseStart(1'b0);
    w = {};
    for (int i = 0; i < 8; i++) w.push_back(32'($urandom));
    buildFrame(8, w, 1'b0, f);
    applyStimulus(f, 1000, 1'b1, nw);
    checkStatus("wrap", 1'b1, 1'b0, 8);

    $display("[TB] random frames");
    for (int t = 0; t < 6; t++) begin
      n   = $urandom_range(1, 6);
      bad = ($urandom_range(0, 2) == 0);
      w   = {};
      for (int i = 0; i < n; i++) w.push_back(32'($urandom));
      pulseStart(1'b0);
      buildFrame(n, w, bad, f);
      applyStimulus(f, 1000, 1'b1, nw);
      checkStatus("random", !bad, bad, n);
    end

    $display("[TB] async reset mid-word");
    pulseStart(1'b0);
    w = {32'h1234_5678, 32'h9ABC_DEF0};
    buildFrame(2, w, 1'b0, f);
    applyStimulus(f, 6, 1'b0, nw);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    pulseStart(1'b0);
    applyStimulus(f, 1000, 1'b0, nw);
    checkStatus("after_reset", 1'b1, 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
